// File: rtl/rails_case_loader.sv
// rails_case_loader: buffers one valid/ready case, replays it to the rails checker and forwards its verdict.
// Define RAILS_LDR_CHECK_EN to reject cases whose data1 entries are not a permutation of 1..N.
module rails_case_loader #(
  parameter int MAX_TRAINS = 10,
  parameter int DW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          in_last,
  input  logic [DW-1:0] in_data1,
  input  logic [DW-1:0] in_data2,
  output logic          chk_rst,
  output logic [DW-1:0] number,
  output logic [DW-1:0] data1,
  output logic [DW-1:0] data2,
  input  logic          chk_valid,
  input  logic          chk_res1,
  input  logic          chk_res2,
  output logic          res_valid,
  output logic          res1,
  output logic          res2,
  output logic          res_err
);
  localparam int CW = $clog2(MAX_TRAINS + 1);
  localparam int TO = 4 * MAX_TRAINS + 8;
  localparam int TW = $clog2(TO + 1);
  typedef enum logic [2:0] {LOAD, LAUNCH, STREAM, WAIT, RESULT} state_t;
  state_t state_q, state_d;
  logic [DW-1:0] buf1_q [MAX_TRAINS];
  logic [DW-1:0] buf1_d [MAX_TRAINS];
  logic [DW-1:0] buf2_q [MAX_TRAINS];
  logic [DW-1:0] buf2_d [MAX_TRAINS];
  logic [CW-1:0] cnt_q, cnt_d, k_q, k_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic          err_q, err_d, in_ready_q, in_ready_d, chk_rst_q, chk_rst_d;
  logic [DW-1:0] number_q, number_d, data1_q, data1_d, data2_q, data2_d;
  logic          res_valid_q, res_valid_d, res1_q, res1_d, res2_q, res2_d, res_err_q, res_err_d;
`ifdef RAILS_LDR_CHECK_EN
  // A valid case sets exactly the low N bits of the seen mask; duplicates or out-of-range ids cannot.
  logic [MAX_TRAINS-1:0] seen_q, seen_d, want;
`endif
  always_comb begin
    state_d     = state_q;
    buf1_d      = buf1_q;
    buf2_d      = buf2_q;
    cnt_d       = cnt_q;
    k_d         = k_q;
    tmr_d       = tmr_q;
    err_d       = err_q;
    in_ready_d  = in_ready_q;
    chk_rst_d   = chk_rst_q;
    number_d    = number_q;
    data1_d     = data1_q;
    data2_d     = data2_q;
    res_valid_d = 1'b0;
    res1_d      = res1_q;
    res2_d      = res2_q;
    res_err_d   = res_err_q;
`ifdef RAILS_LDR_CHECK_EN
    seen_d = seen_q;
    for (int i = 0; i < MAX_TRAINS; i++) want[i] = CW'(i) < cnt_q;
`endif
    case (state_q)
      LOAD: if (in_valid && in_ready_q) begin
        if (cnt_q == CW'(MAX_TRAINS)) err_d = 1'b1;
        else begin
          buf1_d[cnt_q] = in_data1;
          buf2_d[cnt_q] = in_data2;
          cnt_d = cnt_q + 1'b1;
`ifdef RAILS_LDR_CHECK_EN
          for (int i = 0; i < MAX_TRAINS; i++) if (in_data1 == DW'(i + 1)) seen_d[i] = 1'b1;
`endif
        end
        if (in_last) begin
          in_ready_d = 1'b0;
          state_d = LAUNCH;
        end
      end
      LAUNCH: begin
`ifdef RAILS_LDR_CHECK_EN
        if (seen_q != want) err_d = 1'b1;
`endif
        if (err_d) begin
          res_valid_d = 1'b1;
          res1_d = 1'b0;
          res2_d = 1'b0;
          res_err_d = 1'b1;
          state_d = RESULT;
        end else begin
          chk_rst_d = 1'b0;
          number_d = DW'(cnt_q);
          k_d = '0;
          state_d = STREAM;
        end
      end
      STREAM: begin
        data1_d = buf1_q[k_q];
        data2_d = buf2_q[k_q];
        tmr_d = '0;
        k_d = (k_q == cnt_q - 1'b1) ? '0 : k_q + 1'b1;
        state_d = (k_q == cnt_q - 1'b1) ? WAIT : STREAM;
      end
      WAIT: begin
        if (chk_valid || tmr_q == TW'(TO - 1)) begin
          err_d = !chk_valid;
          res_valid_d = 1'b1;
          res1_d = chk_valid & chk_res1;
          res2_d = chk_valid & chk_res2;
          res_err_d = !chk_valid;
          chk_rst_d = 1'b1;
          state_d = RESULT;
        end else tmr_d = tmr_q + 1'b1;
      end
      RESULT: begin
        chk_rst_d = 1'b1;
        cnt_d = '0;
        err_d = 1'b0;
        in_ready_d = 1'b1;
`ifdef RAILS_LDR_CHECK_EN
        seen_d = '0;
`endif
        state_d = LOAD;
      end
      default: state_d = LOAD;
    endcase
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= LOAD;
      buf1_q      <= '{default: '0};
      buf2_q      <= '{default: '0};
      cnt_q       <= '0;
      k_q         <= '0;
      tmr_q       <= '0;
      err_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      chk_rst_q   <= 1'b1;
      number_q    <= '0;
      data1_q     <= '0;
      data2_q     <= '0;
      res_valid_q <= 1'b0;
      res1_q      <= 1'b0;
      res2_q      <= 1'b0;
      res_err_q   <= 1'b0;
`ifdef RAILS_LDR_CHECK_EN
      seen_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      buf1_q      <= buf1_d;
      buf2_q      <= buf2_d;
      cnt_q       <= cnt_d;
      k_q         <= k_d;
      tmr_q       <= tmr_d;
      err_q       <= err_d;
      in_ready_q  <= in_ready_d;
      chk_rst_q   <= chk_rst_d;
      number_q    <= number_d;
      data1_q     <= data1_d;
      data2_q     <= data2_d;
      res_valid_q <= res_valid_d;
      res1_q      <= res1_d;
      res2_q      <= res2_d;
      res_err_q   <= res_err_d;
`ifdef RAILS_LDR_CHECK_EN
      seen_q      <= seen_d;
`endif
    end
  end
  assign in_ready  = in_ready_q;
  assign chk_rst   = chk_rst_q;
  assign number    = number_q;
  assign data1     = data1_q;
  assign data2     = data2_q;
  assign res_valid = res_valid_q;
  assign res1      = res1_q;
  assign res2      = res2_q;
  assign res_err   = res_err_q;
endmodule

// File: tb/tb_rails_case_loader.sv
// tb_rails_case_loader: drives cases, emulates the rails checker, and scores verdict pulses against a queue.
module tb_rails_case_loader;
  localparam int MAX = 10;
  localparam int DW = 4;
  localparam int TO = 4 * MAX + 8;
`ifdef RAILS_LDR_CHECK_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif
  logic clk = 1'b0, reset = 1'b0, in_valid = 1'b0, in_last = 1'b0;
  logic chk_valid = 1'b0, chk_res1 = 1'b0, chk_res2 = 1'b0;
  logic [DW-1:0] in_data1 = '0, in_data2 = '0;
  logic in_ready, chk_rst, res_valid, res1, res2, res_err;
  logic [DW-1:0] number, data1, data2;
  int tests = 0, fails = 0, pulses = 0;
  int v1[16], v2[16];
  typedef struct packed {logic r1; logic r2; logic e;} exp_t;
  exp_t sb[$];
  always #5 clk = ~clk;
  always @(negedge clk) if (res_valid === 1'b1) pulses++;
  rails_case_loader #(.MAX_TRAINS(MAX), .DW(DW)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
    .in_data1(in_data1), .in_data2(in_data2), .chk_rst(chk_rst), .number(number),
    .data1(data1), .data2(data2), .chk_valid(chk_valid), .chk_res1(chk_res1),
    .chk_res2(chk_res2), .res_valid(res_valid), .res1(res1), .res2(res2), .res_err(res_err)
  );
  // Reference rails problem: can 1..n arriving in order leave the station as sequence a via a stack?
  function automatic bit stack_ok(input int a[16], input int n);
    int stk[17];
    int sp = 0;
    int nxt = 1;
    for (int i = 0; i < n; i++) begin
      while (nxt <= n && (sp == 0 || stk[sp-1] != a[i])) begin
        stk[sp] = nxt;
        sp++;
        nxt++;
      end
      if (sp > 0 && stk[sp-1] == a[i]) sp--;
      else return 1'b0;
    end
    return 1'b1;
  endfunction
  function automatic bit perm_ok(input int a[16], input int n);
    bit seen[17];
    for (int i = 0; i < 17; i++) seen[i] = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (a[i] < 1 || a[i] > n || seen[a[i]]) return 1'b0;
      seen[a[i]] = 1'b1;
    end
    return 1'b1;
  endfunction
  task automatic feed(input int n, input bit gaps);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (gaps) repeat ($urandom_range(0, 2)) begin
        in_valid = 1'b0;
        in_data1 = 4'hf;
        @(negedge clk);
      end
      in_valid = 1'b1;
      in_data1 = DW'(v1[i]);
      in_data2 = DW'(v2[i]);
      in_last = (i == n - 1);
    end
    @(negedge clk);
    // With gaps, keep offering a junk last beat during LAUNCH; it must be ignored.
    if (gaps) begin
      in_data1 = 4'hf;
      in_data2 = 4'hf;
    end else begin
      in_valid = 1'b0;
      in_last = 1'b0;
    end
  endtask
  task automatic emulate(input int n, input bit respond);
    tests++;
    if (in_ready !== 1'b0) begin fails++; $display("FAIL launch_ready: got %b expected 0", in_ready); end
    @(negedge clk);
    in_valid = 1'b0;
    in_last = 1'b0;
    tests++;
    if (chk_rst !== 1'b0) begin fails++; $display("FAIL chk_rst_launch: got %b expected 0", chk_rst); end
    tests++;
    if (number !== DW'(n)) begin fails++; $display("FAIL number: got %0d expected %0d", number, n); end
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      tests++;
      if (data1 !== DW'(v1[i]) || data2 !== DW'(v2[i]) || in_ready !== 1'b0) begin
        fails++;
        $display("FAIL stream[%0d]: got d1=%0d d2=%0d rdy=%b expected d1=%0d d2=%0d rdy=0",
                 i, data1, data2, in_ready, v1[i], v2[i]);
      end
    end
    if (respond) begin
      chk_res1 = stack_ok(v1, n);
      chk_res2 = stack_ok(v2, n);
      chk_valid = 1'b1;
    end
  endtask
  task automatic wait_result(input int budget, input bit chk_hi, output int lat);
    exp_t e;
    bit hi_ok = 1'b1;
    lat = 0;
    do begin
      @(negedge clk);
      chk_valid = 1'b0;
      in_valid = 1'b0;
      in_last = 1'b0;
      lat++;
      if (chk_hi && chk_rst !== 1'b1) hi_ok = 1'b0;
    end while (res_valid !== 1'b1 && lat < budget);
    e = (sb.size() > 0) ? sb.pop_front() : 3'b000;
    tests++;
    if (res_valid !== 1'b1) begin
      fails++;
      $display("FAIL result_timeout: got no res_valid expected pulse within %0d cycles", budget);
      return;
    end
    if ({res1, res2, res_err} !== e || in_ready !== 1'b0) begin
      fails++;
      $display("FAIL verdict: got r1=%b r2=%b err=%b rdy=%b expected r1=%b r2=%b err=%b rdy=0",
               res1, res2, res_err, in_ready, e.r1, e.r2, e.e);
    end
    if (chk_hi) begin
      tests++;
      if (!hi_ok) begin fails++; $display("FAIL chk_rst_held: got low expected 1 throughout"); end
    end
    @(negedge clk);
    tests++;
    if (res_valid !== 1'b0 || in_ready !== 1'b1 || chk_rst !== 1'b1) begin
      fails++;
      $display("FAIL after_result: got vld=%b rdy=%b rst=%b expected 0 1 1", res_valid, in_ready, chk_rst);
    end
  endtask
  task automatic run_case(input int n, input bit gaps, input bit respond);
    bit ovf = n > MAX;
    bit bad = !ovf && CHK_EN && !perm_ok(v1, n);
    bit err = ovf || bad || !respond;
    int lat;
    int p0;
    int exp_lat = (ovf || bad || respond) ? 1 : TO;
    sb.push_back(err ? 3'b001 : {stack_ok(v1, n), stack_ok(v2, n), 1'b0});
    p0 = pulses;
    feed(n, gaps);
    if (!ovf && !bad) emulate(n, respond);
    wait_result(TO + 20, ovf || bad, lat);
    tests++;
    if (lat != exp_lat) begin fails++; $display("FAIL latency: got %0d expected %0d", lat, exp_lat); end
    tests++;
    if (pulses != p0 + 1) begin fails++; $display("FAIL pulses: got %0d expected %0d", pulses - p0, 1); end
  endtask
  task automatic check_reset_vals(input string tag);
    tests++;
    if ({in_ready, chk_rst, number, data1, data2, res_valid, res1, res2, res_err} !== {2'b11, 16'h0}) begin
      fails++;
      $display("FAIL %s: got rdy=%b rst=%b num=%0d d1=%0d d2=%0d vld=%b r1=%b r2=%b err=%b expected 1 1 0 0 0 0 0 0 0",
               tag, in_ready, chk_rst, number, data1, data2, res_valid, res1, res2, res_err);
    end
  endtask
  task automatic test_reset();
    repeat (3) @(negedge clk);
    check_reset_vals("reset_state");
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_vals("idle_after_reset");
  endtask
  task automatic test_basic();
    for (int i = 0; i < 5; i++) begin v1[i] = i + 1; v2[i] = 5 - i; end
    run_case(5, 1'b0, 1'b1);
  endtask
  task automatic test_reject();
    v1[0] = 5; v1[1] = 4; v1[2] = 1; v1[3] = 2; v1[4] = 3;
    for (int i = 0; i < 5; i++) v2[i] = i + 1;
    run_case(5, 1'b0, 1'b1);
  endtask
  task automatic test_overflow();
    for (int i = 0; i < 11; i++) begin v1[i] = i + 1; v2[i] = i; end
    run_case(11, 1'b0, 1'b1);
  endtask
  task automatic test_dup();
    v1[0] = 1; v1[1] = 1; v1[2] = 3;
    v2[0] = 1; v2[1] = 2; v2[2] = 3;
    run_case(3, 1'b0, 1'b1);
  endtask
  task automatic test_gaps();
    for (int i = 0; i < 10; i++) begin v1[i] = 10 - i; v2[i] = $urandom_range(0, 15); end
    run_case(10, 1'b1, 1'b1);
  endtask
  task automatic test_timeout();
    v1[0] = 2; v1[1] = 1; v2[0] = 1; v2[1] = 2;
    run_case(2, 1'b0, 1'b0);
  endtask
  task automatic test_reset_mid();
    int p0;
    for (int i = 0; i < 4; i++) begin v1[i] = i + 1; v2[i] = 4 - i; end
    feed(4, 1'b0);
    @(negedge clk);
    @(negedge clk);
    tests++;
    if (data1 !== 4'd1 || chk_rst !== 1'b0) begin
      fails++;
      $display("FAIL pre_reset_stream: got d1=%0d rst=%b expected 1 0", data1, chk_rst);
    end
    reset = 1'b0;
    @(posedge clk);
    #1;
    check_reset_vals("mid_reset");
    @(negedge clk);
    reset = 1'b1;
    p0 = pulses;
    repeat (TO + 10) @(negedge clk);
    tests++;
    if (pulses != p0) begin fails++; $display("FAIL aborted_pulse: got %0d expected 0", pulses - p0); end
    test_basic();
  endtask
  task automatic test_back_to_back();
    for (int c = 0; c < 6; c++) begin
      int n = $urandom_range(1, MAX);
      for (int i = 0; i < n; i++) begin v1[i] = i + 1; v2[i] = $urandom_range(0, 15); end
      for (int i = n - 1; i > 0; i--) begin
        int j = $urandom_range(0, i);
        int t = v1[i];
        v1[i] = v1[j];
        v1[j] = t;
      end
      if ($urandom_range(0, 3) == 0) v1[$urandom_range(0, n - 1)] = $urandom_range(0, 15);
      run_case(n, 1'($urandom_range(0, 1)), 1'b1);
    end
  endtask
  initial begin
    test_reset();
    test_basic();
    test_reject();
    test_overflow();
    test_dup();
    test_gaps();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
